// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder.
//   SHA256_CHUNK_WORDS : 32-bit words per 512-bit chunk
//   SHA256_PAD_BYTE    : marker byte appended after the message
//   state_e            : padder FSM states
//   bswap32            : byte-reverse a 32-bit word (used for length words)
package sha256_pkg;

  localparam int unsigned SHA256_CHUNK_WORDS = 16;
  localparam logic [7:0]  SHA256_PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    DATA,
    PAD80,
    ZERO,
    LEN_HI,
    LEN_LO
  } state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Stream interface between a message producer and the SHA-256 padder.
//   in_*  : message words, byte 0 in [7:0], in_last/in_nbytes mark the tail
//   out_* : padded chunk words toward the message-schedule block
// modport master : producer / downstream side (drives in_*, out_ready)
// modport slave  : padder side
interface sha256_msg_padder_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_chunk_last;
  logic        out_msg_last;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, out_ready,
    input  in_ready, out_valid, out_data, out_chunk_last, out_msg_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, out_ready,
    output in_ready, out_valid, out_data, out_chunk_last, out_msg_last
  );

endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: passes message words through, then appends the
// 0x80 marker, zero fill and the 64-bit big-endian bit length so that every
// chunk is exactly 16 words.
//   clk     : clock
//   rst     : synchronous active-high reset
//   bus     : slave side of the in/out word streams
//   len_ovf : sticky, set when the byte counter wraps; cleared by rst only
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  sha256_msg_padder_if.slave   bus,
  output logic                 len_ovf
);

  localparam int unsigned      IDX_W    = $clog2(SHA256_CHUNK_WORDS);
  localparam logic [IDX_W-1:0] IDX_PRE  = IDX_W'(SHA256_CHUNK_WORDS - 3);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SHA256_CHUNK_WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic             chunk_last_q;
  logic             msg_last_q;

  logic             slot_free;
  logic             in_ready_c;
  logic             emit;
  logic [31:0]      word_d;
  logic             msg_last_d;
  logic [2:0]       nbytes_eff;
  logic [31:0]      pad_word;
  logic [LEN_W:0]   cnt_sum;
  logic [63:0]      bitlen;

  assign slot_free  = !out_valid_q || bus.out_ready;
  assign nbytes_eff = (!bus.in_last || bus.in_nbytes > 3'd4) ? 3'd4 : bus.in_nbytes;
  assign cnt_sum    = {1'b0, cnt_q} + (LEN_W + 1)'(nbytes_eff);
  assign bitlen     = 64'({cnt_q, 3'b000});

  // Tail word: keep bytes below nbytes, marker at nbytes, zeros above.
  always_comb begin
    pad_word = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (3'(b) < nbytes_eff)       pad_word[8*b +: 8] = bus.in_data[8*b +: 8];
      else if (3'(b) == nbytes_eff) pad_word[8*b +: 8] = SHA256_PAD_BYTE;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= DATA;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      DATA: begin
        if (emit && bus.in_last) begin
          if (nbytes_eff == 3'd4)  state_d = PAD80;
          else if (idx_q == IDX_PRE) state_d = LEN_HI;
          else                     state_d = ZERO;
        end
      end
      PAD80:  if (emit) state_d = (idx_q == IDX_PRE) ? LEN_HI : ZERO;
      ZERO:   if (emit && idx_q == IDX_PRE) state_d = LEN_HI;
      LEN_HI: if (emit) state_d = LEN_LO;
      LEN_LO: if (emit) state_d = DATA;
      default: state_d = DATA;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    in_ready_c = 1'b0;
    emit       = 1'b0;
    word_d     = '0;
    msg_last_d = 1'b0;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    case (state_q)
      DATA: begin
        in_ready_c = slot_free && !rst;
        emit       = bus.in_valid && in_ready_c;
        if (emit) begin
          word_d = (nbytes_eff == 3'd4) ? bus.in_data : pad_word;
          cnt_d  = cnt_sum[LEN_W-1:0];
          ovf_d  = ovf_q | cnt_sum[LEN_W];
        end
      end
      PAD80: begin
        emit   = slot_free;
        word_d = {24'h0, SHA256_PAD_BYTE};
      end
      ZERO: begin
        emit = slot_free;
      end
      LEN_HI: begin
        emit   = slot_free;
        word_d = bswap32(bitlen[63:32]);
      end
      LEN_LO: begin
        emit       = slot_free;
        word_d     = bswap32(bitlen[31:0]);
        msg_last_d = 1'b1;
        if (emit) cnt_d = '0;
      end
      default: ;
    endcase
  end

  // Output register, word index and byte counter
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      chunk_last_q <= 1'b0;
      msg_last_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= emit || (out_valid_q && !bus.out_ready);
      if (emit) begin
        idx_q        <= idx_q + IDX_W'(1);
        out_data_q   <= word_d;
        chunk_last_q <= (idx_q == IDX_LAST);
        msg_last_q   <= msg_last_d;
      end
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_chunk_last = chunk_last_q;
  assign bus.out_msg_last   = msg_last_q;
  assign len_ovf            = ovf_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed self-checking bench for sha256_msg_padder.
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  logic rst;
  logic len_ovf;

  sha256_msg_padder_if bus ();

  sha256_msg_padder #(.LEN_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .len_ovf (len_ovf)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [31:0] obs_d[$];
  logic        obs_cl[$];
  logic        obs_ml[$];
  int unsigned msg_seen = 0;
  logic [31:0] exp_q[$];

  // A word is transferred at the next posedge when valid&ready hold here.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      obs_d.push_back(bus.out_data);
      obs_cl.push_back(bus.out_chunk_last);
      obs_ml.push_back(bus.out_msg_last);
      if (bus.out_msg_last) msg_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int unsigned i);
    return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
  endfunction

  // Called at posedge+1; returns at posedge+1 right after acceptance.
  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nb,
                      output int unsigned waited);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.in_nbytes = nb;
    waited        = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    chk("send_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_msg(input string tag, input int unsigned prev);
    int unsigned n = 0;
    while (msg_seen == prev && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(msg_seen > prev), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_msg(input string tag, input int unsigned base);
    chk({tag, "_len"}, 32'(obs_d.size()) - base, 32'(exp_q.size()));
    for (int unsigned i = 0; i < 32'(exp_q.size()); i++) begin
      if (int'(base + i) < obs_d.size()) begin
        chk($sformatf("%s_w%0d", tag, i), obs_d[base+i], exp_q[i]);
        chk($sformatf("%s_cl%0d", tag, i), 32'(obs_cl[base+i]), 32'(i % 16 == 15));
        chk($sformatf("%s_ml%0d", tag, i), 32'(obs_ml[base+i]), 32'(i == 32'(exp_q.size()) - 1));
      end
    end
  endtask

  task automatic exp_zeros(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back(32'h0);
  endtask

  task automatic exp_abc();
    exp_q.delete();
    exp_q.push_back(32'h80636261);
    exp_zeros(14);
    exp_q.push_back(32'h18000000);
  endtask

  initial begin
    int unsigned base, prev, w;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_nbytes = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_chunk_last", 32'(bus.out_chunk_last), 32'd0);
    chk("rst_msg_last", 32'(bus.out_msg_last), 32'd0);
    chk("rst_len_ovf", 32'(len_ovf), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // "abc"
    base = obs_d.size(); prev = msg_seen;
    exp_abc();
    send(32'h00636261, 1'b1, 3'd3, w);
    wait_msg("abc", prev);
    check_msg("abc", base);

    // Empty message: garbage data must be masked away
    base = obs_d.size(); prev = msg_seen;
    exp_q.delete();
    exp_q.push_back(32'h00000080);
    exp_zeros(15);
    send(32'hDEADBEEF, 1'b1, 3'd0, w);
    wait_msg("empty", prev);
    check_msg("empty", base);

    // 55 bytes: marker lands at index 13, single chunk
    base = obs_d.size(); prev = msg_seen;
    exp_q.delete();
    for (int unsigned i = 0; i < 13; i++) exp_q.push_back(mword(i));
    exp_q.push_back(32'h80363534);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hB8010000);
    for (int unsigned i = 0; i < 13; i++) send(mword(i), 1'b0, 3'd1, w);
    send(32'h37363534, 1'b1, 3'd3, w);
    wait_msg("b55", prev);
    check_msg("b55", base);

    // 56 bytes: nbytes=7 treated as 4, marker at 14, spills into chunk 2
    base = obs_d.size(); prev = msg_seen;
    exp_q.delete();
    for (int unsigned i = 0; i < 14; i++) exp_q.push_back(mword(i));
    exp_q.push_back(32'h00000080);
    exp_zeros(16);
    exp_q.push_back(32'hC0010000);
    for (int unsigned i = 0; i < 13; i++) send(mword(i), 1'b0, 3'd4, w);
    send(mword(13), 1'b1, 3'd7, w);
    wait_msg("b56", prev);
    check_msg("b56", base);

    // Backpressure mid-chunk, 22-byte message
    base = obs_d.size(); prev = msg_seen;
    exp_q.delete();
    for (int unsigned i = 0; i < 5; i++) exp_q.push_back(mword(i));
    exp_q.push_back(32'h0080DDCC);
    exp_zeros(9);
    exp_q.push_back(32'hB0000000);
    for (int unsigned i = 0; i < 3; i++) send(mword(i), 1'b0, 3'd4, w);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = mword(3);
    bus.in_last   = 1'b0;
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_data%0d", c), bus.out_data, mword(2));
      chk($sformatf("bp_cl%0d", c), 32'(bus.out_chunk_last), 32'd0);
      chk($sformatf("bp_in_ready%0d", c), 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(mword(3), 1'b0, 3'd4, w);
    chk("bp_tput3", w, 32'd0);
    send(mword(4), 1'b0, 3'd4, w);
    chk("bp_tput4", w, 32'd0);
    send(32'hFFEEDDCC, 1'b1, 3'd2, w);
    chk("bp_tput5", w, 32'd0);
    wait_msg("bp", prev);
    check_msg("bp", base);

    // Reset at index 7 abandons the message
    for (int unsigned i = 0; i < 7; i++) send(mword(i), 1'b0, 3'd4, w);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out_data", bus.out_data, 32'h0);
    @(posedge clk);
    #1;
    base = obs_d.size(); prev = msg_seen;
    exp_abc();
    send(32'h00636261, 1'b1, 3'd3, w);
    wait_msg("abc2", prev);
    check_msg("abc2", base);

    chk("end_len_ovf", 32'(len_ovf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Producer-side front end for the SHA-256 message-schedule block. Accepts an arbitrary-length byte message as 32-bit words and appends the SHA-256 padding: the 0x80 marker, zero fill, and the 64-bit big-endian bit length. Emits exactly 16 words per 512-bit chunk on a ready/valid interface that drives the schedule block's word-load input. Output words use the same lane convention as the input: message byte 0 in bits [7:0]. The downstream block byte-swaps each word.

Parameters:
LEN_W, 32, width of the message byte counter (bit length = counter << 3, zero-extended to 64 bits)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset, single clock domain
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
in_data  in  32  message bytes, byte 0 in [7:0]
in_last  in  1  final word of message
in_nbytes  in  3  valid bytes in the last word (0..4); ignored when in_last=0 (treated as 4)
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts the word
out_data  out  32  padded chunk word, same lane order as in_data
out_chunk_last  out  1  qualifies word index 15 of a chunk
out_msg_last  out  1  qualifies the final word of the final chunk of a message
len_ovf  out  1  sticky flag: byte counter wrapped; cleared only by rst

Behaviour:
- Reset (rst=1 at clk edge): state=DATA; word index=0; byte count=0; out_valid=0; out_data=0; out_chunk_last=0; out_msg_last=0; len_ovf=0; in_ready=0 during reset. Reset mid-message abandons the message; no partial padding is emitted.
- Output stage is a single register. A slot is free when !out_valid | out_ready. Holding (out_valid & !out_ready) keeps out_data and both flags stable.
- in_ready = (state==DATA) & slot free. Latency is 1 cycle from acceptance to out_valid. Throughput is 1 word/cycle.
- Word index (0..15) increments on every output handshake and wraps 15->0. out_chunk_last = (index==15).
- States:
  - DATA: pass accepted words through; byte count += 4 (or in_nbytes on last).
    - Last word with nbytes 0..3: emit a word holding data bytes [0..n-1], 0x80 in byte n, zeros above. Go to ZERO, or go to LEN_HI if that word sat at index 13.
    - Last word with nbytes=4: emit data unchanged, then go to PAD80.
  - PAD80: emit 0x00000080. Next state is ZERO, or LEN_HI if the emitted index was 13.
  - ZERO: emit 0x00000000 until the next index is 14 (wrap through 15->0 if needed), then go to LEN_HI.
  - LEN_HI: emit bswap(bitlen[63:32]) at index 14.
  - LEN_LO: emit bswap(bitlen[31:0]) at index 15 with out_msg_last=1, then clear byte count and return to DATA.
- If the 0x80 word lands at index 14 or 15, the padding spills into an extra chunk: zero fill to 15, then zeros 0..13, then the length words.
- bitlen = {count, 3'b000}, zero-extended to 64 bits. If count carries out, set len_ovf and let the counter wrap.
- in_nbytes > 4 on a last word is treated as 4.

Decomposition:
- Shared package sha256_pkg:
  - SHA256_CHUNK_WORDS=16
  - SHA256_PAD_BYTE=8'h80
  - state enum (DATA, PAD80, ZERO, LEN_HI, LEN_LO)
  - function bswap32
- No sub-module; single flat module.

Test Plan:
- "abc": in_data=0x00636261, nbytes=3, last -> 0x80636261, 14x 0x00000000, then 0x18000000 with out_msg_last; out_chunk_last on word 16.
- Empty message: nbytes=0, last -> 0x00000080, 15x zero; word 15=0x00000000 with msg_last=1 (bitlen 0).
- 55 bytes: 13 full words + last nbytes=3 -> 0x80 at index 13, index14=0, index15=0xB8010000; exactly one chunk.
- 56 bytes: 14 words, last nbytes=4 -> 0x00000080 at index 14, zero at 15, then chunk 2 zeros 0..13, index14=0, index15=0xC0010000; 32 words total.
- Backpressure: out_ready low for 5 cycles mid-chunk -> out_data/flags stable, in_ready=0, no word lost or duplicated; then resumes 1 word/cycle.
- rst asserted at index 7 of a message -> next cycle out_valid=0, index=0, count=0; a following "abc" produces the exact "abc" vector.
